// File: rtl/display_sequencer.sv
// display_sequencer: turns one-cycle game events into timed
// displayAddr/nivel sequences for the six-digit message memory.
module display_sequencer #(
  parameter int T_NIVEL = 100,
  parameter int T_BLINK = 25,
  parameter int N_BLINK = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mostra_nivel,
  input  logic       nivel_in,
  input  logic       venceu,
  input  logic       perdeu,
  input  logic       limpa,
  output logic [1:0] displayAddr,
  output logic       nivel,
  output logic       ocupado,
  output logic       pronto
);

  localparam int TMAX = (T_NIVEL > T_BLINK) ? T_NIVEL : T_BLINK;
  localparam int PW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(N_BLINK + 1);

  localparam logic [PW-1:0] NIV_END  = PW'(T_NIVEL - 1);
  localparam logic [PW-1:0] BLK_END  = PW'(T_BLINK - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(N_BLINK - 1);
  localparam logic [PW-1:0] PC_ONE   = PW'(1);
  localparam logic [BW-1:0] BC_ONE   = BW'(1);

  localparam logic [1:0] A_NIVEL = 2'b00;
  localparam logic [1:0] A_BLANK = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    NIVEL     = 3'd1,
    PISCA_ON  = 3'd2,
    PISCA_OFF = 3'd3,
    FIXO      = 3'd4
  } state_t;

  state_t          state;
  logic [PW-1:0]   pc;
  logic [BW-1:0]   bc;
  logic            lose_q;
  logic            result_req;
  logic            nivel_ok;

  // Result message code: 01 win, 10 lose.
  function automatic logic [1:0] msg(input logic lose);
    return lose ? 2'b10 : 2'b01;
  endfunction

  assign result_req = perdeu | venceu;

  // The level banner may only interrupt non-blinking states.
  assign nivel_ok = (state == IDLE) ||
                    (state == NIVEL) ||
                    (state == FIXO);

  // Sequencer FSM; every output is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= '0;
      bc          <= '0;
      lose_q      <= 1'b0;
      displayAddr <= A_BLANK;
      nivel       <= 1'b0;
      ocupado     <= 1'b0;
      pronto      <= 1'b0;
    end else begin
      pronto <= 1'b0;
      if (limpa) begin
        state       <= IDLE;
        pc          <= '0;
        bc          <= '0;
        displayAddr <= A_BLANK;
        ocupado     <= 1'b0;
      end else if (result_req) begin
        lose_q      <= perdeu;
        pc          <= '0;
        bc          <= '0;
        state       <= PISCA_ON;
        displayAddr <= msg(perdeu);
        ocupado     <= 1'b1;
      end else if (mostra_nivel && nivel_ok) begin
        nivel       <= nivel_in;
        pc          <= '0;
        state       <= NIVEL;
        displayAddr <= A_NIVEL;
        ocupado     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            displayAddr <= A_BLANK;
            ocupado     <= 1'b0;
          end
          NIVEL: begin
            if (pc == NIV_END) begin
              state       <= IDLE;
              pc          <= '0;
              displayAddr <= A_BLANK;
              ocupado     <= 1'b0;
            end else begin
              pc <= pc + PC_ONE;
            end
          end
          PISCA_ON: begin
            if (pc == BLK_END) begin
              pc <= '0;
              bc <= bc + BC_ONE;
              if (bc == BLK_LAST) begin
                state       <= FIXO;
                displayAddr <= msg(lose_q);
                ocupado     <= 1'b0;
                pronto      <= 1'b1;
              end else begin
                state       <= PISCA_OFF;
                displayAddr <= A_BLANK;
              end
            end else begin
              pc <= pc + PC_ONE;
            end
          end
          PISCA_OFF: begin
            if (pc == BLK_END) begin
              pc          <= '0;
              state       <= PISCA_ON;
              displayAddr <= msg(lose_q);
            end else begin
              pc <= pc + PC_ONE;
            end
          end
          FIXO: begin
            displayAddr <= msg(lose_q);
            ocupado     <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            pc          <= '0;
            bc          <= '0;
            displayAddr <= A_BLANK;
            ocupado     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_display_sequencer.sv
// tb_display_sequencer: directed vector table plus randomized
// run against a time-since-event reference model.
module tb_display_sequencer;

  localparam int TN   = 4;
  localparam int TB   = 2;
  localparam int NB   = 2;
  localparam int SPAN = (2 * NB - 1) * TB;

  logic       clock = 1'b0;
  logic       reset;
  logic       mostra_nivel;
  logic       nivel_in;
  logic       venceu;
  logic       perdeu;
  logic       limpa;
  logic [1:0] displayAddr;
  logic       nivel;
  logic       ocupado;
  logic       pronto;

  int checks = 0;
  int fails  = 0;

  display_sequencer #(
    .T_NIVEL(TN),
    .T_BLINK(TB),
    .N_BLINK(NB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .mostra_nivel(mostra_nivel),
    .nivel_in    (nivel_in),
    .venceu      (venceu),
    .perdeu      (perdeu),
    .limpa       (limpa),
    .displayAddr (displayAddr),
    .nivel       (nivel),
    .ocupado     (ocupado),
    .pronto      (pronto)
  );

  always #5 clock = ~clock;

  // inputs {rst,mn,ni,v,p,l}; expected {addr,nivel,ocupado,pronto}
  typedef struct packed {
    logic [5:0] in;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: mode plus cycles elapsed since it started.
  // 0 idle, 1 level banner, 2 result message
  int m_mode = 0;
  int m_age  = 0;
  bit m_lose = 0;
  bit m_niv  = 0;

  function automatic logic [1:0] m_msg();
    return m_lose ? 2'b10 : 2'b01;
  endfunction

  task automatic model_step(input logic [5:0] in);
    bit blinking;
    blinking = (m_mode == 2) && (m_age < SPAN);
    if (in[5]) begin
      m_mode = 0; m_niv = 0; m_age = 0;
    end else if (in[0]) begin
      m_mode = 0; m_age = 0;
    end else if (in[2] || in[1]) begin
      m_mode = 2; m_lose = in[1]; m_age = 0;
    end else if (in[4] && !blinking) begin
      m_mode = 1; m_niv = in[3]; m_age = 0;
    end else begin
      m_age++;
    end
    if (m_mode == 1 && m_age >= TN) m_mode = 0;
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] a;
    logic oc, pr;
    a = 2'b11; oc = 0; pr = 0;
    if (m_mode == 1) begin
      a = 2'b00; oc = 1;
    end else if (m_mode == 2) begin
      if (m_age < SPAN) begin
        oc = 1;
        a = ((m_age / TB) % 2 == 0) ? m_msg() : 2'b11;
      end else begin
        a = m_msg();
        pr = (m_age == SPAN);
      end
    end
    return {a, m_niv, oc, pr};
  endfunction

  task automatic drive(input logic [5:0] in);
    reset        = in[5];
    mostra_nivel = in[4];
    nivel_in     = in[3];
    venceu       = in[2];
    perdeu       = in[1];
    limpa        = in[0];
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {displayAddr, nivel, ocupado, pronto};
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got addr=%b nivel=%b ocupado=%b pronto=%b, want addr=%b nivel=%b ocupado=%b pronto=%b",
               name, act[4:3], act[2], act[1], act[0],
               exp[4:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic [5:0] in, input logic [4:0] exp);
    vec_t v;
    v.in = in;
    v.exp = exp;
    tbl.push_back(v);
  endtask

  localparam logic [5:0] RST = 6'b100000;
  localparam logic [5:0] NOP = 6'b000000;
  localparam logic [5:0] MN1 = 6'b011000;
  localparam logic [5:0] MN0 = 6'b010000;
  localparam logic [5:0] VEN = 6'b000100;
  localparam logic [5:0] PER = 6'b000010;
  localparam logic [5:0] VP  = 6'b000110;
  localparam logic [5:0] LIM = 6'b000001;

  initial begin
    drive(RST);

    // 1: reset and idle
    add(RST, 5'b11_0_0_0);
    add(RST, 5'b11_0_0_0);
    add(NOP, 5'b11_0_0_0);
    add(NOP, 5'b11_0_0_0);
    // 2: level banner for exactly TN cycles
    add(MN1, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(NOP, 5'b11_1_0_0);
    add(NOP, 5'b11_1_0_0);
    // 3: win blink then hold
    add(VEN, 5'b01_1_1_0);
    add(NOP, 5'b01_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(NOP, 5'b01_1_1_0);
    add(NOP, 5'b01_1_1_0);
    add(NOP, 5'b01_1_0_1);
    add(NOP, 5'b01_1_0_0);
    // 4: simultaneous win+lose -> lose
    add(VP,  5'b10_1_1_0);
    add(NOP, 5'b10_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(NOP, 5'b10_1_1_0);
    add(NOP, 5'b10_1_1_0);
    add(NOP, 5'b10_1_0_1);
    add(NOP, 5'b10_1_0_0);
    // 5: lose interrupts banner; banner ignored in PISCA_OFF
    add(MN1, 5'b00_1_1_0);
    add(PER, 5'b10_1_1_0);
    add(NOP, 5'b10_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(MN0, 5'b11_1_1_0);
    add(NOP, 5'b10_1_1_0);
    add(NOP, 5'b10_1_1_0);
    add(NOP, 5'b10_1_0_1);
    // 6: limpa mid PISCA_OFF keeps nivel, no pronto
    add(VEN, 5'b01_1_1_0);
    add(NOP, 5'b01_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(LIM, 5'b11_1_0_0);
    add(NOP, 5'b11_1_0_0);
    add(NOP, 5'b11_1_0_0);
    // 6: reset mid PISCA_OFF, then a fresh win sequence
    add(VEN, 5'b01_1_1_0);
    add(NOP, 5'b01_1_1_0);
    add(NOP, 5'b11_1_1_0);
    add(RST, 5'b11_0_0_0);
    add(NOP, 5'b11_0_0_0);
    add(VEN, 5'b01_0_1_0);
    add(NOP, 5'b01_0_1_0);
    add(NOP, 5'b11_0_1_0);
    add(NOP, 5'b11_0_1_0);
    add(NOP, 5'b01_0_1_0);
    add(NOP, 5'b01_0_1_0);
    add(NOP, 5'b01_0_0_1);
    add(NOP, 5'b01_0_0_0);
    // repeat banner request restarts the window
    add(MN1, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(MN1, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(NOP, 5'b00_1_1_0);
    add(NOP, 5'b11_1_0_0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].in);
      @(posedge clock);
      model_step(tbl[i].in);
      #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    for (int i = 0; i < 4000; i++) begin
      logic [5:0] in;
      in = '0;
      in[5] = ($urandom_range(0, 199) == 0);
      in[4] = ($urandom_range(0, 7) == 0);
      in[3] = 1'($urandom_range(0, 1));
      in[2] = ($urandom_range(0, 24) == 0);
      in[1] = ($urandom_range(0, 24) == 0);
      in[0] = ($urandom_range(0, 39) == 0);
      drive(in);
      @(posedge clock);
      model_step(in);
      #1;
      check($sformatf("rand%0d", i), model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
